// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM read sequencer.
// Optional feature macro used by the top: SRAM_SEQ_CHECKSUM_EN.
package sram_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_CAPTURE,
        S_HOLD,
        S_FINISH
    } seq_state_t;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;
    localparam int CKSUM_W    = 16;

endpackage

// File: rtl/sram_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared by the SETUP and STROBE intervals of the read sequencer.
module sram_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sram_read_sequencer.sv
// Sweeps the external SRAM with programmable setup/strobe timing and hands each
// captured address/data pair downstream. Define SRAM_SEQ_CHECKSUM_EN for a running checksum.
module sram_read_sequencer
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_read,
    input  logic [DATA_W-1:0]   sram_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [ADDR_W-1:0]   smp_addr,
    output logic [DATA_W-1:0]   smp_data,
`ifdef SRAM_SEQ_CHECKSUM_EN
    output logic [CKSUM_W-1:0]  checksum,
`endif
    output logic                busy,
    output logic                done
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    // Timer is loaded with N-1 on entry so the interval lasts exactly N cycles.
    localparam logic [TMR_W-1:0] SETUP_LOAD  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] STROBE_LOAD = TMR_W'(STROBE_CYC - 1);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;
    logic              accept;
    logic              handshake;
    logic              last_word;

    assign accept    = (state == S_IDLE) && start;
    assign handshake = (state == S_HOLD) && smp_ready;
    assign last_word = (remaining == (ADDR_W + 1)'(1));

    sram_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = SETUP_LOAD;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_SETUP;
                        tmr_load  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_nxt = S_FINISH;
                end else if (tmr_expired) begin
                    state_nxt = S_STROBE;
                    tmr_load  = 1'b1;
                    tmr_val   = STROBE_LOAD;
                end
            end
            S_STROBE: begin
                if (abort)            state_nxt = S_FINISH;
                else if (tmr_expired) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = abort ? S_FINISH : S_HOLD;
            S_HOLD: begin
                // A same-cycle handshake still completes; abort only blocks the next word.
                if (handshake) begin
                    if (abort || last_word) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_SETUP;
                        tmr_load  = 1'b1;
                    end
                end else if (abort) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FINISH);
        sram_read = (state == S_STROBE);
        smp_valid = (state == S_HOLD);
    end

    assign sram_addr = cur_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            smp_addr  <= '0;
            smp_data  <= '0;
        end else begin
            if (accept && (word_count != '0)) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
            end
            if ((state == S_CAPTURE) && !abort) begin
                smp_addr <= cur_addr;
                smp_data <= sram_data;
            end
            if (handshake) begin
                remaining <= remaining - 1'b1;
                if (!last_word) cur_addr <= cur_addr + 1'b1;
            end
        end
    end

`ifdef SRAM_SEQ_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)            checksum <= '0;
        else if (accept)    checksum <= '0;
        else if (handshake) checksum <= checksum + CKSUM_W'(smp_data);
    end
`endif

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Scoreboarded bench for sram_read_sequencer: stimulus queues expected samples,
// an independent monitor pops and compares on each valid/ready handshake.
module tb_sram_read_sequencer;
    import sram_seq_pkg::*;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int SETUP_CYC  = 2;
    localparam int STROBE_CYC = 3;
    localparam int WORD_CYC   = SETUP_CYC + STROBE_CYC + 2;

    logic              clk = 1'b0;
    logic              rst, start, abort, smp_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] sram_addr, smp_addr;
    logic              sram_read, smp_valid, busy, done;
    logic [DATA_W-1:0] sram_data, smp_data;
`ifdef SRAM_SEQ_CHECKSUM_EN
    logic [CKSUM_W-1:0] checksum;
`endif

    sram_read_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .sram_addr  (sram_addr),
        .sram_read  (sram_read),
        .sram_data  (sram_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_addr   (smp_addr),
        .smp_data   (smp_data),
`ifdef SRAM_SEQ_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sample_t;

    int      vectors = 0;
    int      miscompares = 0;
    int      cyc = 0;
    int      read_cycles = 0;
    int      valid_cycles = 0;
    int      done_cnt = 0;
    int      ready_mode = 0;       // 0: always ready, 1: random, 2: stalled
    logic [7:0]  key = 8'h00;
    bit          const_ff = 1'b0;
    logic [15:0] exp_sum = 16'h0;
    sample_t exp_q[$];
    int      hs_cyc[$];

    // SRAM contents: a keyed function of the address, or all 0xFF.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return const_ff ? 8'hFF : (a[7:0] ^ key);
    endfunction

    assign sram_data = mem_word(sram_addr);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready generator.
    initial begin
        smp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       smp_ready = 1'b1;
                1:       smp_ready = 1'($urandom_range(0, 1));
                default: smp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, hold-stability and activity counters.
    initial begin
        static bit                pv_stall = 1'b0;
        static logic [ADDR_W-1:0] pa = '0;
        static logic [DATA_W-1:0] pd = '0;
        sample_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv_stall = 1'b0;
                continue;
            end
            if (sram_read) read_cycles++;
            if (smp_valid) valid_cycles++;
            if (done)      done_cnt++;
            if (pv_stall && smp_valid) begin
                check("hold_addr_stable", 32'(smp_addr), 32'(pa));
                check("hold_data_stable", 32'(smp_data), 32'(pd));
            end
            if (smp_valid && smp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_sample: got addr 0x%0h data 0x%0h, expected none", smp_addr, smp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_addr", 32'(smp_addr), 32'(e.addr));
                    check("sample_data", 32'(smp_data), 32'(e.data));
                end
                hs_cyc.push_back(cyc);
            end
            pv_stall = smp_valid && !smp_ready;
            pa = smp_addr;
            pd = smp_data;
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return done;
            1:       return smp_valid;
            default: return sram_read;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string name, output int n);
        n = 0;
        while (!sig(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sig(sel)), 32'd1);
    endtask

    // Expected samples: word i of a sweep reads address (base + i) mod 2^ADDR_W.
    task automatic issue(input int base, input int count, input int n_expect);
        sample_t s;
        exp_sum = 16'h0;
        for (int i = 0; i < n_expect; i++) begin
            s.addr = ADDR_W'((base + i) % (1 << ADDR_W));
            s.data = mem_word(s.addr);
            exp_q.push_back(s);
            exp_sum = 16'((int'(exp_sum) + int'(s.data)) % 65536);
        end
        @(negedge clk);
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W + 1)'(count);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic run(input int base, input int count, input int budget, input string name);
        int n;
        issue(base, count, count);
        wait_for(0, budget, name, n);
        @(negedge clk);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
`ifdef SRAM_SEQ_CHECKSUM_EN
        check({name, "_checksum"}, 32'(checksum), 32'(exp_sum));
`endif
    endtask

    initial begin
        int n, r0, v0, d0, h0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_read", 32'(sram_read), 32'd0);
        check("rst_smp_valid", 32'(smp_valid), 32'd0);
        check("rst_smp_addr", 32'(smp_addr), 32'd0);
        check("rst_smp_data", 32'(smp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sweep with ready tied high.
        key = 8'hA5; ready_mode = 0;
        r0 = read_cycles; d0 = done_cnt; h0 = hs_cyc.size();
        issue(32'h0010, 4, 4);
        check("basic_busy", 32'(busy), 32'd1);
        wait_for(0, 100, "basic_done", n);
        @(negedge clk);
        check("basic_read_cycles", 32'(read_cycles - r0), 32'(4 * STROBE_CYC));
        check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("basic_handshakes", 32'(hs_cyc.size() - h0), 32'd4);
        for (int i = 1; i < 4; i++)
            if (hs_cyc.size() > h0 + i)
                check("basic_word_period", 32'(hs_cyc[h0 + i] - hs_cyc[h0 + i - 1]), 32'(WORD_CYC));
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Backpressure: sample held, no new strobe while stalled.
        ready_mode = 2;
        issue(32'h0100, 2, 2);
        wait_for(1, 50, "bp_valid", n);
        r0 = read_cycles;
        repeat (10) @(negedge clk);
        check("bp_no_strobe", 32'(read_cycles - r0), 32'd0);
        check("bp_valid_held", 32'(smp_valid), 32'd1);
        ready_mode = 0;
        wait_for(0, 100, "bp_done", n);
        @(negedge clk);
        check("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Address wrap with random backpressure.
        ready_mode = 1;
        run(32'h7FFE, 3, 400, "wrap");

        // Randomised sweeps.
        for (int t = 0; t < 6; t++) begin
            key = 8'($urandom);
            run(int'($urandom_range(0, (1 << ADDR_W) - 1)), int'($urandom_range(1, 6)), 600, "rand");
        end

        // Zero word count: done quickly, no strobe, no sample.
        ready_mode = 0;
        r0 = read_cycles; v0 = valid_cycles; d0 = done_cnt;
        issue(32'h0055, 0, 0);
        wait_for(0, 2, "zero_done", n);
        check("zero_done_latency", 32'(n <= 1), 32'd1);
        @(negedge clk);
        check("zero_no_read", 32'(read_cycles - r0), 32'd0);
        check("zero_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("zero_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Abort in the second STROBE: only the first sample appears.
        key = 8'h3C; h0 = hs_cyc.size();
        issue(32'h0200, 4, 1);
        n = 0;
        while (hs_cyc.size() == h0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        wait_for(2, 20, "abort_second_strobe", n);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_read_drop", 32'(sram_read), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_samples", 32'(hs_cyc.size() - h0), 32'd1);
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

        // Abort while a sample is pending in HOLD drops it.
        ready_mode = 2;
        issue(32'h0250, 3, 0);
        wait_for(1, 50, "hold_abort_valid", n);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_valid_drop", 32'(smp_valid), 32'd0);
        check("hold_abort_done", 32'(done), 32'd1);
        ready_mode = 0;
        @(negedge clk);

        // Synchronous reset while in HOLD.
        ready_mode = 2;
        issue(32'h0300, 2, 2);
        wait_for(1, 50, "rst_hold_valid", n);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_hold_sram_read", 32'(sram_read), 32'd0);
        check("rst_hold_smp_valid", 32'(smp_valid), 32'd0);
        check("rst_hold_smp_addr", 32'(smp_addr), 32'd0);
        check("rst_hold_smp_data", 32'(smp_data), 32'd0);
        check("rst_hold_busy", 32'(busy), 32'd0);
        check("rst_hold_done", 32'(done), 32'd0);
        exp_q.delete();
        ready_mode = 0;
        rst = 1'b0;
        @(negedge clk);

        // Four 0xFF words: checksum 0x03FC when the feature is built in.
        const_ff = 1'b1; ready_mode = 1;
        run(32'h0400, 4, 400, "ff_words");
`ifdef SRAM_SEQ_CHECKSUM_EN
        check("checksum_ff_words", 32'(checksum), 32'h03FC);
`endif
        const_ff = 1'b0;

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/sram_read_sequencer.md
Name: sram_read_sequencer

Overview:
Sequences read sweeps of the external SRAM for the sampling path. Given a start address and word count, it drives the address bus and read strobe with programmable setup and strobe timing, then captures the data bus once per word. Each captured address/data pair is presented to the downstream logger through a valid/ready handshake. It sits between the host command logic and the SRAM pins, and replaces free-running manual strobing.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- SETUP_CYC, 2, cycles the address is stable before the strobe rises (min 1).
- STROBE_CYC, 3, cycles the strobe stays high before data capture (min 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  stop the sweep at the next cycle boundary.
- base_addr  in  ADDR_W  first address; sampled on an accepted start.
- word_count  in  ADDR_W+1  number of words to read; sampled on an accepted start.
- sram_addr  out  ADDR_W  address bus to the SRAM.
- sram_read  out  1  read strobe to the SRAM and capture logic.
- sram_data  in  DATA_W  SRAM data bus.
- smp_valid  out  1  captured sample available.
- smp_ready  in  1  downstream accepts the sample.
- smp_addr  out  ADDR_W  address of the sample.
- smp_data  out  DATA_W  data of the sample.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a sweep finishes or is aborted.

Behaviour:
- Reset: state=IDLE; sram_addr=0, sram_read=0, smp_valid=0, smp_addr=0, smp_data=0, busy=0, done=0. Internal counters are cleared. Reset wins over all other inputs in any state.
- States: IDLE, SETUP, STROBE, CAPTURE, HOLD, FINISH.
- IDLE: on start=1:
  - If word_count=0, go to FINISH.
  - Otherwise latch cur_addr=base_addr and remaining=word_count, drive sram_addr=base_addr, and go to SETUP.
- SETUP: hold sram_addr for SETUP_CYC cycles, then go to STROBE.
- STROBE: sram_read=1 for exactly STROBE_CYC cycles, then go to CAPTURE.
- CAPTURE (one cycle):
  - sram_read=0.
  - Register smp_addr=cur_addr and smp_data=sram_data (the value present on this clock edge).
  - Set smp_valid=1 and go to HOLD.
- HOLD:
  - smp_valid, smp_addr and smp_data stay stable until smp_valid && smp_ready.
  - On the handshake, in the same cycle: smp_valid drops next cycle and remaining decrements.
  - If remaining was 1, go to FINISH.
  - Otherwise cur_addr increments and sram_addr is updated the next cycle; go to SETUP.
- FINISH: done=1 for one cycle, then go to IDLE.
- Per-word latency (ready held high): SETUP_CYC + STROBE_CYC + 2 cycles, from SETUP entry to the handshake.
- Address wrap: cur_addr increments modulo 2^ADDR_W (0x7FFF to 0x0000). word_count up to 2^ADDR_W reads the whole array once.
- Abort: sampled in every state except IDLE and FINISH.
  - In SETUP, STROBE or CAPTURE: drop sram_read and go to FINISH; no sample is produced.
  - In HOLD: the pending sample is dropped (smp_valid=0) and the state goes to FINISH.
  - If abort and the handshake occur in the same HOLD cycle, the handshake completes first, then FINISH.
- start while busy is ignored. start and abort together in IDLE: start wins, abort is ignored.

Optional Feature:
SRAM_SEQ_CHECKSUM_EN
- Defined: adds output port checksum (16 bits). It is cleared on an accepted start and updated on each handshake: checksum = checksum + zero-extended smp_data, modulo 2^16. It stays stable after done.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package sram_seq_pkg: state enum (seq_state_t), default ADDR_W and DATA_W constants, checksum width constant (16).
- One natural sub-module, sram_seq_timer: a loadable down-counter with load value and expire flag, instanced once and reused for the SETUP and STROBE intervals.

Test Plan:
- Basic sweep: base=0x0010, count=4, ready tied 1, SRAM model returns addr[7:0]^0xA5 → samples (0x0010,0xB5) through (0x0013,0xB6); sram_read high 3 cycles per word; done pulses once; 7 cycles per word.
- Backpressure: hold ready low 10 cycles in HOLD → smp_* stay stable; no new strobe until accepted.
- Wrap: base=0x7FFE, count=3 → addresses 0x7FFE, 0x7FFF, 0x0000.
- Zero count: start with count=0 → done asserts within 2 cycles; no sram_read and no smp_valid.
- Abort: abort during the 2nd STROBE → sram_read drops next cycle; only 1 sample emitted; done pulses. Also synchronous rst mid-HOLD → all outputs return to reset values next edge.
- Checksum (macro defined): 4 words 0xFF each → checksum=0x03FC; with the macro undefined the same run passes without the port.
